// File: rtl/counter_scheduler.sv
// Round-robin scheduler granting bursts of increments to four counters of mixed widths,
// with per-counter wrap pulses and a registered sum of all counters.
module counter_scheduler #(
   parameter int SIZE = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [3:0]        req,
   input  logic [7:0]        weight,
   output logic [3:0]        gnt,
   output logic              busy,
   output logic [3:0]        wrap,
   output logic [2*SIZE-1:0] sum
);

   localparam int W0 = SIZE;
   localparam int W1 = SIZE / 2;
   localparam int W3 = SIZE / 8;
   localparam int SW = 2 * SIZE;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q;
   logic [1:0]    last_q;
   logic [3:0]    gnt_q;
   logic [2:0]    rem_q;
   logic [W0-1:0] c0_q, c0_d;
   logic [W1-1:0] c1_q, c1_d;
   logic [W1-1:0] c2_q, c2_d;
   logic [W3-1:0] c3_q, c3_d;
   logic [3:0]    wrap_q, wrap_d;
   logic [SW-1:0] sum_q, sum_d;

   logic [3:0]    inc;
   logic [1:0]    win, idx;
   logic          found;

   // Search upward starting just past the last winner.
   always_comb begin
      win   = last_q;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      inc       = (state_q == BUSY) ? (gnt_q & req) : 4'b0000;
      c0_d      = c0_q + W0'(inc[0]);
      c1_d      = c1_q + W1'(inc[1]);
      c2_d      = c2_q + W1'(inc[2]);
      c3_d      = c3_q + W3'(inc[3]);
      wrap_d[0] = inc[0] & (&c0_q);
      wrap_d[1] = inc[1] & (&c1_q);
      wrap_d[2] = inc[2] & (&c2_q);
      wrap_d[3] = inc[3] & (&c3_q);
      sum_d     = {{(SW-W0){1'b0}}, c0_q} + {{(SW-W1){1'b0}}, c1_q}
                + {{(SW-W1){1'b0}}, c2_q} + {{(SW-W3){1'b0}}, c3_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         gnt_q   <= '0;
         rem_q   <= '0;
         c0_q    <= '0;
         c1_q    <= '0;
         c2_q    <= '0;
         c3_q    <= '0;
         wrap_q  <= '0;
         sum_q   <= '0;
      end else begin
         // sum keeps tracking the counters one cycle late, even through a clear
         sum_q <= sum_d;
         if (clr) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            gnt_q   <= '0;
            rem_q   <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            wrap_q  <= '0;
         end else begin
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            c2_q   <= c2_d;
            c3_q   <= c3_d;
            wrap_q <= wrap_d;
            case (state_q)
               IDLE: begin
                  if (found) begin
                     state_q <= BUSY;
                     gnt_q   <= 4'b0001 << win;
                     last_q  <= win;
                     rem_q   <= 3'(weight[{win, 1'b0} +: 2]) + 3'd1;
                  end
               end
               BUSY: begin
                  if (|inc) begin
                     rem_q <= rem_q - 3'd1;
                     if (rem_q == 3'd1) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                     end
                  end else begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state_q == BUSY);
   assign wrap = wrap_q;
   assign sum  = sum_q;

endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning width of the widest counter; SIZE SHALL be a multiple of 8 and at least 8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous clear of counters, pointer and grant.
REQ-005 SHALL have port req  input  4  per-requester increment request; bit i is requester i.
REQ-006 SHALL have port weight  input  8  burst length per requester: bits [2i+1:2i] give weight+1 increments, range 1..4.
REQ-007 SHALL have port gnt  output  4  registered one-hot grant; all-zero when no grant.
REQ-008 SHALL have port busy  output  1  high while in state BUSY.
REQ-009 SHALL have port wrap  output  4  one-cycle pulse when counter i wraps from all-ones to zero.
REQ-010 SHALL have port sum  output  2*SIZE  registered sum of all four counters.

Function
REQ-011 SHALL hold four internal counters: c0 SIZE bits, c1 SIZE/2, c2 SIZE/2, c3 SIZE/8; each increments by 1 modulo 2^width.
REQ-012 SHALL implement FSM with two states: IDLE and BUSY.
REQ-013 In IDLE with req != 0, SHALL pick a winner round-robin, searching from (last+1) mod 4 upward; next cycle state=BUSY, gnt=onehot(winner), last=winner.
REQ-014 SHALL sample the winner's weight field at the IDLE->BUSY transition; weight changes during BUSY SHALL have no effect.
REQ-015 In IDLE with req == 0, SHALL stay in IDLE with gnt=0.
REQ-016 In BUSY, each cycle with req[g]=1 SHALL increment counter g and decrement the remaining-burst count.
REQ-017 BUSY SHALL end (next state IDLE, gnt=0) after the cycle performing the final burst increment.
REQ-018 In BUSY with req[g]=0, SHALL perform no increment and go to IDLE next cycle (grant abort).
REQ-019 SHALL insert exactly one IDLE cycle between consecutive grants.
REQ-020 Only the granted counter SHALL ever change; non-granted requests SHALL be ignored during BUSY.
REQ-021 wrap[i] SHALL pulse high for the single cycle following the increment that takes counter i from all-ones to zero.
REQ-022 sum SHALL equal c0+c1+c2+c3, each zero-extended to 2*SIZE bits, registered one cycle after the counter values; no overflow is possible.
REQ-023 clr=1 SHALL take priority over all other activity: next cycle counters=0, gnt=0, state=IDLE, last=3, wrap=0.
REQ-024 A BUSY grant in progress when clr is asserted SHALL be aborted without incrementing.

Reset
REQ-025 rst low SHALL immediately force: counters=0, gnt=0, busy=0, wrap=0, sum=0, state=IDLE, last=3 (requester 0 first).
REQ-026 After rst rises, the first arbitration SHALL occur on the first rising clk edge.

Verification
REQ-027 Reset, req=0001, weight=0x03 -> gnt=0001 for 4 cycles, c0=4, then IDLE; sum=4 one cycle after the last increment.
REQ-028 req=1111, weight=0x00 held -> gnt sequence 0001,0,0010,0,0100,0,1000,0,0001; each counter advances by 1 per round.
REQ-029 SIZE=8, req=1000, weight[7:6]=1 -> c3 goes 0->1->0; wrap=1000 for one cycle after the second increment; sum returns to its prior value.
REQ-030 req=0010, weight[3:2]=3; drop req[1] after 2 increments -> c1=2, busy falls the next cycle, no further c1 change.
REQ-031 clr pulsed mid-burst with c0=5 -> next cycle all counters 0, gnt=0, busy=0; sum=0 one cycle later; next grant goes to requester 0.
REQ-032 rst low asynchronously mid-burst -> gnt, busy, wrap and sum read 0 before the next clk edge.
